// File: rtl/sdr_cmd_ctrl_if.sv
// Command-controller bus: UART byte input and the tuning, gain and status outputs.
interface sdr_cmd_ctrl_if #(
  parameter int PHASE_WIDTH  = 64,
  parameter int GAIN_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                                rx_valid;
  logic [7:0]                          rx_byte;
  logic [NUM_CHANNELS*PHASE_WIDTH-1:0] phase_inc;
  logic [GAIN_WIDTH-1:0]               cic_gain;
  logic [CH_W-1:0]                     active_ch;
  logic                                update;
  logic                                cmd_error;
  logic                                busy;

  modport master (
    output rx_valid, rx_byte,
    input  phase_inc, cic_gain, active_ch, update, cmd_error, busy
  );

  modport slave (
    input  rx_valid, rx_byte,
    output phase_inc, cic_gain, active_ch, update, cmd_error, busy
  );
endinterface

// File: rtl/sdr_cmd_ctrl.sv
// UART command decoder for SDR tuning: presets, saturating tuning steps,
// CIC gain select, channel select and hex phase-increment entry.
module sdr_cmd_ctrl #(
  parameter int PHASE_WIDTH  = 64,
  parameter int GAIN_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int GAIN_MAX     = 3,
  parameter logic [PHASE_WIDTH-1:0] PRESET0     = PHASE_WIDTH'(64'h4CF41F212D77318),
  parameter logic [PHASE_WIDTH-1:0] PRESET1     = PHASE_WIDTH'(64'h1AA60F8B8911654),
  parameter logic [PHASE_WIDTH-1:0] PRESET2     = PHASE_WIDTH'(64'h1DC38C076704516D),
  parameter logic [PHASE_WIDTH-1:0] PRESET3     = PHASE_WIDTH'(64'h1D60D923295482C6),
  parameter logic [PHASE_WIDTH-1:0] STEP_FINE   = PHASE_WIDTH'(64'h1436A8CDF6F3),
  parameter logic [PHASE_WIDTH-1:0] STEP_MID    = PHASE_WIDTH'(64'hCA22980BA57E),
  parameter logic [PHASE_WIDTH-1:0] STEP_COARSE = PHASE_WIDTH'(64'h71B375868D170),
  parameter int unsigned TIMEOUT_CYCLES = 80000000
) (
  input logic           clk,
  input logic           rst_n,
  sdr_cmd_ctrl_if.slave bus
);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int NDIG  = PHASE_WIDTH / 4;
  localparam int DIG_W = $clog2(NDIG + 1);
  localparam logic [PHASE_WIDTH:0] LIMIT    = {2'b00, {(PHASE_WIDTH-1){1'b1}}};
  localparam logic [31:0]          TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, HEX} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_d [NUM_CHANNELS];
  logic [GAIN_WIDTH-1:0]  gain_q, gain_d;
  logic [CH_W-1:0]        active_q, active_d;
  logic [PHASE_WIDTH-1:0] shadow_q, shadow_d;
  logic [DIG_W-1:0]       digits_q, digits_d;
  logic [31:0]            tmo_q, tmo_d;
  logic                   update_q, update_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic [PHASE_WIDTH-1:0] cur, new_val, step;
  logic [PHASE_WIDTH:0]   sum, diff;
  logic                   wr, do_step, step_up;
  logic [7:0]             dig;
  logic [4:0]             hex;

  // {valid, nibble} for an ASCII hex digit of either case
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= "0" && c <= "9")      r = {1'b1, c[3:0]};
    else if (c >= "a" && c <= "f") r = {1'b1, 4'(c - 8'h57)};
    else if (c >= "A" && c <= "F") r = {1'b1, 4'(c - 8'h37)};
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    gain_d   = gain_q;
    active_d = active_q;
    shadow_d = shadow_q;
    digits_d = digits_q;
    tmo_d    = tmo_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    wr       = 1'b0;
    do_step  = 1'b0;
    step_up  = 1'b0;
    step     = '0;
    dig      = bus.rx_byte - 8'h30;
    hex      = hex_nib(bus.rx_byte);

    cur = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++)
      if (active_q == CH_W'(k)) cur = phase_q[k];
    new_val = cur;

    unique case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_byte >= "0" && bus.rx_byte <= "9") begin
          if (32'(dig) <= GAIN_MAX) begin
            gain_d   = GAIN_WIDTH'(dig);
            update_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          case (bus.rx_byte)
            "a": begin new_val = PRESET0; wr = 1'b1; end
            "b": begin new_val = PRESET1; wr = 1'b1; end
            "f": begin new_val = PRESET2; wr = 1'b1; end
            "g": begin new_val = PRESET3; wr = 1'b1; end
            "p": begin step = STEP_FINE;   step_up = 1'b1; do_step = 1'b1; end
            "o": begin step = STEP_FINE;                   do_step = 1'b1; end
            "r": begin step = STEP_MID;    step_up = 1'b1; do_step = 1'b1; end
            "q": begin step = STEP_MID;                    do_step = 1'b1; end
            "m": begin step = STEP_COARSE; step_up = 1'b1; do_step = 1'b1; end
            "n": begin step = STEP_COARSE;                 do_step = 1'b1; end
            "c": if (NUM_CHANNELS > 1) begin
              active_d = (active_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : active_q + 1'b1;
              update_d = 1'b1;
            end
            "F": begin
              shadow_d = '0;
              digits_d = '0;
              tmo_d    = '0;
              state_d  = HEX;
            end
            default: ;
          endcase
        end
      end

      HEX: begin
        tmo_d = tmo_q + 32'd1;
        if (bus.rx_valid) begin
          tmo_d   = '0;
          state_d = IDLE;
          if (bus.rx_byte == 8'h0D) begin
            if (digits_q == DIG_W'(NDIG)) begin
              new_val = shadow_q;
              wr      = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.rx_byte != 8'h1B) begin
            if (hex[4] && digits_q != DIG_W'(NDIG)) begin
              shadow_d = {shadow_q[PHASE_WIDTH-5:0], hex[3:0]};
              digits_d = digits_q + 1'b1;
              state_d  = HEX;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Both directions clamp into [0, LIMIT]; a clamped step still writes the limit.
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (do_step) begin
      wr = 1'b1;
      if (step_up) begin
        if (sum > LIMIT) begin new_val = LIMIT[PHASE_WIDTH-1:0]; err_d = 1'b1; end
        else             new_val = sum[PHASE_WIDTH-1:0];
      end else begin
        if (diff[PHASE_WIDTH])  begin new_val = '0;                       err_d = 1'b1; end
        else if (diff > LIMIT)  begin new_val = LIMIT[PHASE_WIDTH-1:0]; err_d = 1'b1; end
        else                    new_val = diff[PHASE_WIDTH-1:0];
      end
    end

    if (wr) begin
      update_d = 1'b1;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++)
        if (active_q == CH_W'(k)) phase_d[k] = new_val;
    end

    busy_d = (state_d == HEX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) phase_q[k] <= PRESET0;
      gain_q   <= '0;
      active_q <= '0;
      shadow_q <= '0;
      digits_q <= '0;
      tmo_q    <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      gain_q   <= gain_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      digits_q <= digits_d;
      tmo_q    <= tmo_d;
      update_q <= update_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
    assign bus.phase_inc[g*PHASE_WIDTH +: PHASE_WIDTH] = phase_q[g];
  end

  assign bus.cic_gain  = gain_q;
  assign bus.active_ch = active_q;
  assign bus.update    = update_q;
  assign bus.cmd_error = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sdr_cmd_ctrl.sv
// Directed bench for sdr_cmd_ctrl: two 64-bit channels, 100-cycle hex timeout.
module tb_sdr_cmd_ctrl;
  localparam logic [63:0] P0 = 64'h04CF41F212D77318;
  localparam logic [63:0] P1 = 64'h01AA60F8B8911654;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   fails = 0;
  int   n;

  always #5 clk = ~clk;

  sdr_cmd_ctrl_if #(.PHASE_WIDTH(64), .GAIN_WIDTH(8), .NUM_CHANNELS(2)) bus ();

  sdr_cmd_ctrl #(
    .PHASE_WIDTH(64), .GAIN_WIDTH(8), .NUM_CHANNELS(2), .GAIN_MAX(3),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  function automatic logic [63:0] ch(input int k);
    return bus.phase_inc[k*64 +: 64];
  endfunction

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (3) tick();

    check("rst_phase", bus.phase_inc, {P0, P0});
    check("rst_gain",  bus.cic_gain, 0);
    check("rst_act",   bus.active_ch, 0);
    check("rst_flags", {bus.update, bus.cmd_error, bus.busy}, 3'b000);
    rst_n = 1'b1;
    tick();

    send("b");
    check("b_ch0", ch(0), P1);
    check("b_ch1", ch(1), P0);
    check("b_upd", bus.update, 1);
    tick();
    check("b_upd_pulse", bus.update, 0);

    send("2");
    check("g2_gain", bus.cic_gain, 2);
    check("g2_upd",  {bus.update, bus.cmd_error}, 2'b10);
    send("7");
    check("g7_gain", bus.cic_gain, 2);
    check("g7_flags", {bus.update, bus.cmd_error}, 2'b01);
    tick();
    check("g7_err_pulse", bus.cmd_error, 0);

    send("p");
    check("p_ch0", ch(0), 64'h01AA752F615F0D47);
    check("p_flags", {bus.update, bus.cmd_error}, 2'b10);
    send("o");
    check("o_ch0", ch(0), P1);

    send("c");
    check("c_act", bus.active_ch, 1);
    check("c_upd", bus.update, 1);
    send("F");
    check("F_busy", {bus.busy, bus.update, bus.cmd_error}, 3'b100);
    send_str("000000000000ABCD");
    check("hex_busy", {bus.busy, bus.update}, 2'b10);
    send(8'h0D);
    check("cr_ch1",  ch(1), 64'h000000000000ABCD);
    check("cr_ch0",  ch(0), P1);
    check("cr_flags", {bus.busy, bus.update, bus.cmd_error}, 3'b010);
    check("cr_act",  bus.active_ch, 1);

    send("F");
    send_str("12");
    send(8'h0D);
    check("short_flags", {bus.busy, bus.update, bus.cmd_error}, 3'b001);
    check("short_phase", bus.phase_inc, {64'h000000000000ABCD, P1});
    send("F");
    send(8'h1B);
    check("esc_flags", {bus.busy, bus.update, bus.cmd_error}, 3'b000);
    send("z");
    check("junk_flags", {bus.update, bus.cmd_error}, 2'b00);

    send("c");
    check("wrap_act", bus.active_ch, 0);
    send("F");
    send_str("7FFFFFFFFFFF0000");
    send(8'h0D);
    check("load_ch0", ch(0), 64'h7FFFFFFFFFFF0000);
    send("m");
    check("sat_hi_ch0", ch(0), 64'h7FFFFFFFFFFFFFFF);
    check("sat_hi_flags", {bus.update, bus.cmd_error}, 2'b11);
    check("sat_hi_ch1", ch(1), 64'h000000000000ABCD);
    send("F");
    send_str("0000000000000000");
    send(8'h0D);
    check("zero_ch0", ch(0), 64'h0);
    send("o");
    check("sat_lo_ch0", ch(0), 64'h0);
    check("sat_lo_err", bus.cmd_error, 1);

    send("F");
    send_str("1111111111111111");
    check("full_busy", bus.busy, 1);
    send("2");
    check("ovf_flags", {bus.busy, bus.update, bus.cmd_error}, 3'b001);
    check("ovf_ch0", ch(0), 64'h0);

    send("F");
    send_str("12345");
    n = 0;
    while (n < 120 && bus.cmd_error !== 1'b1) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 100);
    check("tmo_busy", bus.busy, 0);
    send(8'h0D);
    check("tmo_cr_flags", {bus.update, bus.cmd_error}, 2'b00);
    check("tmo_cr_phase", bus.phase_inc, {64'h000000000000ABCD, 64'h0});

    send("F");
    send_str("AB");
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h0D;
    tick();
    bus.rx_valid = 1'b0;
    check("mid_rst_phase", bus.phase_inc, {P0, P0});
    check("mid_rst_state", {bus.cic_gain, bus.active_ch}, 9'h0);
    check("mid_rst_flags", {bus.busy, bus.update, bus.cmd_error}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h0D);
    check("post_rst_cr", {bus.busy, bus.update, bus.cmd_error}, 3'b000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
